ota_cmp_scheduler: RTL and testbench

- Time-shares the single digital-OTA comparator between NREQ requesters.
- Per granted request: steers the analog input mux to that requester's pair and enables the OTA. It then waits a programmable settle time, majority-votes NSAMP synchronized samples of the OTA output, and reports one result tagged with the requester ID.
- Sits between the requester logic in the tile top level and the OTA cell / input mux.

---
 rtl/ota_cmp_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_ota_cmp_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ota_cmp_scheduler.sv
// ota_cmp_scheduler
//
// Time-shares one digital-OTA comparator between NREQ requesters. A
// round-robin arbiter picks one requester and steers the analog input mux
// to its pair. The block then enables the OTA and waits a programmable
// settle time. It majority-votes NSAMP synchronized samples of the OTA
// output and reports one result tagged with the requester ID.
//
// State table
//   state  | meaning
//   IDLE   | no conversion; arbitrate pending requests
//   SETTLE | OTA enabled, mux steered, waiting settle_cycles clocks
//   SAMPLE | counting ones on the synchronized OTA output, NSAMP clocks
//   REPORT | done pulse, result valid, grant/OTA released
//
// Ports
//   clk            single clock
//   rst            asynchronous active-high reset
//   req[NREQ]      level request per requester
//   settle_cycles  settle wait in clk cycles, captured at grant
//   ota_out        raw OTA output, asynchronous to clk
//   ota_en         OTA output-stage enable
//   mux_sel[IDW]   analog input-pair select (granted ID)
//   grant[NREQ]    one-hot grant, zero when idle
//   busy           high in any state other than IDLE
//   done           one-cycle result-valid pulse
//   result         majority-vote comparison result
//   result_id[IDW] requester ID owning result

module ota_cmp_scheduler #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int NSAMP = 3,
  parameter int SETW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [SETW-1:0] settle_cycles,
  input  logic            ota_out,
  output logic            ota_en,
  output logic [IDW-1:0]  mux_sel,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            done,
  output logic            result,
  output logic [IDW-1:0]  result_id
);

  localparam int CW = $clog2(NSAMP + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t          state, state_nxt;

  logic            s1, s2;
  logic [SETW-1:0] settle_cnt, settle_nxt;
  logic [CW-1:0]   ones_cnt, ones_nxt;
  logic [CW-1:0]   samp_cnt, samp_nxt;
  logic [IDW-1:0]  last, last_nxt;

  logic [NREQ-1:0] grant_nxt;
  logic            ota_en_nxt;
  logic [IDW-1:0]  mux_sel_nxt;
  logic            done_nxt;
  logic            result_nxt;
  logic [IDW-1:0]  result_id_nxt;

  logic            arb_found;
  logic [IDW-1:0]  arb_id;
  logic [IDW-1:0]  cand;

  logic [CW-1:0]   ones_total;
  logic            vote;

  // Two-flop synchronizer, free-running in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ota_out;
      s2 <= s1;
    end
  end

  // Round-robin search starting one above the last served ID. NREQ is a
  // power of two, so the IDW-bit add wraps modulo NREQ on its own; the last
  // candidate (i == NREQ) is the last-served ID itself, giving it lowest
  // priority.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last + IDW'(i);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_id    = cand;
      end
    end
  end

  // Running count including the sample taken this cycle.
  assign ones_total = ones_cnt + CW'(s2);
  assign vote       = (ones_total > CW'(NSAMP / 2));

  always_comb begin
    state_nxt     = state;
    settle_nxt    = settle_cnt;
    ones_nxt      = ones_cnt;
    samp_nxt      = samp_cnt;
    last_nxt      = last;
    grant_nxt     = grant;
    ota_en_nxt    = ota_en;
    mux_sel_nxt   = mux_sel;
    done_nxt      = 1'b0;
    result_nxt    = result;
    result_id_nxt = result_id;

    unique case (state)
      ST_IDLE: begin
        if (arb_found) begin
          grant_nxt   = NREQ'(1) << arb_id;
          mux_sel_nxt = arb_id;
          ota_en_nxt  = 1'b1;
          settle_nxt  = settle_cycles;
          ones_nxt    = '0;
          samp_nxt    = '0;
          state_nxt   = (settle_cycles != '0) ? ST_SETTLE : ST_SAMPLE;
        end
      end

      ST_SETTLE: begin
        settle_nxt = settle_cnt - SETW'(1);
        if (settle_cnt <= SETW'(1)) begin
          state_nxt = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        ones_nxt = ones_total;
        if (samp_cnt == CW'(NSAMP - 1)) begin
          samp_nxt      = '0;
          result_nxt    = vote;
          result_id_nxt = mux_sel;
          done_nxt      = 1'b1;
          grant_nxt     = '0;
          ota_en_nxt    = 1'b0;
          state_nxt     = ST_REPORT;
        end else begin
          samp_nxt = samp_cnt + CW'(1);
        end
      end

      ST_REPORT: begin
        last_nxt  = mux_sel;
        ones_nxt  = '0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      ones_cnt   <= '0;
      samp_cnt   <= '0;
      last       <= IDW'(NREQ - 1);
      grant      <= '0;
      ota_en     <= 1'b0;
      mux_sel    <= '0;
      done       <= 1'b0;
      result     <= 1'b0;
      result_id  <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      ones_cnt   <= ones_nxt;
      samp_cnt   <= samp_nxt;
      last       <= last_nxt;
      grant      <= grant_nxt;
      ota_en     <= ota_en_nxt;
      mux_sel    <= mux_sel_nxt;
      done       <= done_nxt;
      result     <= result_nxt;
      result_id  <= result_id_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ota_cmp_scheduler.sv
// Testbench for ota_cmp_scheduler: a transaction-level model predicts every
// output each cycle from the round-robin, settle/sample timing and
// majority-vote rules, and directed scenarios add literal expectations.

module tb_ota_cmp_scheduler;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int NSAMP = 3;
  localparam int SETW  = 4;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [SETW-1:0] settle_cycles;
  logic            ota_out;
  logic            ota_en;
  logic [IDW-1:0]  mux_sel;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            done;
  logic            result;
  logic [IDW-1:0]  result_id;

  ota_cmp_scheduler #(
    .NREQ(NREQ), .IDW(IDW), .NSAMP(NSAMP), .SETW(SETW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .settle_cycles(settle_cycles),
    .ota_out(ota_out),
    .ota_en(ota_en),
    .mux_sel(mux_sel),
    .grant(grant),
    .busy(busy),
    .done(done),
    .result(result),
    .result_id(result_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   hist [0:8191];
  int   n_edge   = 0;
  int   rel_edge = 0;
  bit   m_busy   = 0;
  int   m_id     = 0;
  int   m_start  = 0;
  int   m_s      = 0;
  int   m_last   = NREQ - 1;
  bit   m_res    = 0;
  int   m_rid    = 0;
  int   e_grant  = 0;
  bit   e_ota    = 0;
  bit   e_busy   = 0;
  bit   e_done   = 0;
  int   grant_log[$];

  // Synchronized value in use before edge e: OTA value captured two edges
  // earlier, or zero if that edge was before the last reset release.
  function automatic bit s2_at(input int e);
    if (e - 2 < rel_edge) return 1'b0;
    return hist[e - 2];
  endfunction

  function automatic int rr_pick(input int last_id, input logic [NREQ-1:0] r);
    for (int d = 1; d <= NREQ; d++) begin
      if (r[(last_id + d) % NREQ]) return (last_id + d) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   = 0;
      m_last   = NREQ - 1;
      m_res    = 0;
      m_rid    = 0;
      e_grant  = 0;
      e_ota    = 0;
      e_busy   = 0;
      e_done   = 0;
      rel_edge = n_edge;
    end else begin
      int n, t, tend, ones;
      n = n_edge;
      hist[n] = ota_out;
      n_edge++;
      if (!m_busy) begin
        if (req != '0) begin
          m_id    = rr_pick(m_last, req);
          m_busy  = 1;
          m_start = n;
          m_s     = int'(settle_cycles);
          grant_log.push_back(m_id);
        end
      end else begin
        t    = n - m_start;
        tend = m_s + NSAMP;
        if (t == tend) begin
          ones = 0;
          for (int e = m_start + m_s + 1; e <= m_start + tend; e++) ones += int'(s2_at(e));
          m_res = (ones > NSAMP / 2);
          m_rid = m_id;
        end else if (t == tend + 1) begin
          m_busy = 0;
          m_last = m_id;
        end
      end
      if (m_busy) begin
        t    = n - m_start;
        tend = m_s + NSAMP;
        e_busy = 1;
        if (t < tend) begin
          e_grant = 1 << m_id;
          e_ota   = 1;
          e_done  = 0;
        end else begin
          e_grant = 0;
          e_ota   = 0;
          e_done  = 1;
        end
      end else begin
        e_grant = 0;
        e_ota   = 0;
        e_busy  = 0;
        e_done  = 0;
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant", int'(grant), e_grant);
      chk("ota_en", int'(ota_en), int'(e_ota));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("result", int'(result), int'(m_res));
      chk("result_id", int'(result_id), m_rid);
      chk("grant_onehot0", int'($onehot0(grant)), 1);
      if (e_ota) chk("mux_sel", int'(mux_sel), m_id);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    tick(2);
    #2 rst = 1'b0;
  endtask

  // Counts negedges until done is seen (bounded), ota_en-high cycles on the
  // way, and the first non-zero grant observed.
  task automatic wait_done(output int lat, output int en, output int first_grant);
    lat = 0;
    en = 0;
    first_grant = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (ota_en) en++;
      if (first_grant == 0 && grant != '0) first_grant = int'(grant);
      if (done) break;
      if (lat > 60) begin
        n_tests++;
        n_fail++;
        $display("FAIL wait_done_timeout: no done after %0d cycles", lat);
        break;
      end
    end
  endtask

  int lat, en, fg;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    settle_cycles = 4'd4;
    ota_out = 1'b1;
    tick(3);
    chk("reset_grant", int'(grant), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ota_en", int'(ota_en), 0);
    chk("reset_result", int'(result), 0);
    #2 rst = 1'b0;

    // Single request, S=4: grant next edge, 7 enable cycles, done at 8th negedge.
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    chk("t1_grant", int'(grant), 4'b0100);
    chk("t1_mux_sel", int'(mux_sel), 2);
    wait_done(lat, en, fg);
    chk("t1_latency", lat + 1, 8);
    chk("t1_en_cycles", en + 1, 7);
    chk("t1_result", int'(result), 1);
    chk("t1_result_id", int'(result_id), 2);
    req = '0;
    @(negedge clk);
    chk("t1_grant_release", int'(grant), 0);

    // All requesting, OTA low: order 0,1,2,3,0 from reset pointer.
    do_reset();
    grant_log.delete();
    ota_out = 1'b0;
    settle_cycles = 4'd2;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done(lat, en, fg);
      chk("t2_result", int'(result), 0);
    end
    req = '0;
    chk("t2_n_grants", grant_log.size(), 5);
    if (grant_log.size() >= 5) begin
      chk("t2_order0", grant_log[0], 0);
      chk("t2_order1", grant_log[1], 1);
      chk("t2_order2", grant_log[2], 2);
      chk("t2_order3", grant_log[3], 3);
      chk("t2_order4", grant_log[4], 0);
    end

    // Zero settle: SETTLE skipped, 3 enable cycles, done 3 cycles after grant.
    tick(2);
    ota_out = 1'b1;
    settle_cycles = 4'd0;
    req = 4'b0010;
    wait_done(lat, en, fg);
    chk("t3_first_grant", fg, 4'b0010);
    chk("t3_latency", lat, 4);
    chk("t3_en_cycles", en, 3);
    chk("t3_result", int'(result), 1);
    req = '0;

    // Majority vote: synchronized samples 1,0,1 then 0,1,0.
    for (int v = 0; v < 2; v++) begin
      logic [2:0] pat;
      pat = (v == 0) ? 3'b101 : 3'b010;
      tick(2);
      ota_out = pat[2];
      @(negedge clk);
      ota_out = pat[1];
      settle_cycles = 4'd0;
      req = 4'b0001;
      @(negedge clk);
      ota_out = pat[0];
      wait_done(lat, en, fg);
      chk("t4_vote_latency", lat, 3);
      chk("t4_vote_result", int'(result), (v == 0) ? 1 : 0);
      chk("t4_vote_id", int'(result_id), 0);
      req = '0;
    end

    // Request dropped during SETTLE: conversion still reports.
    tick(2);
    ota_out = 1'b1;
    settle_cycles = 4'd5;
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_mid", int'(busy), 1);
    req = '0;
    wait_done(lat, en, fg);
    chk("t5_result_id", int'(result_id), 1);
    tick(3);
    chk("t5_idle_grant", int'(grant), 0);
    chk("t5_idle_busy", int'(busy), 0);

    // Reset during SAMPLE, then pointer-reset priority.
    settle_cycles = 4'd2;
    req = 4'b0100;
    tick(4);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_grant", int'(grant), 0);
    chk("t6_rst_ota_en", int'(ota_en), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    req = 4'b1001;
    tick(2);
    #2 rst = 1'b0;
    wait_done(lat, en, fg);
    chk("t6_first_grant", fg, 4'b0001);
    chk("t6_first_id", int'(result_id), 0);
    req = 4'b1000;
    wait_done(lat, en, fg);
    chk("t6_second_grant", fg, 4'b1000);
    chk("t6_second_id", int'(result_id), 3);
    req = '0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
